// File: rtl/seq_fsm_pkg.sv
// Shared types and default parameters for the seq_fsm_gen pattern sequencer.
package seq_fsm_pkg;

    localparam int unsigned N_STATES_DEF   = 4;
    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned WDOG_LIMIT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_wdog.sv
// Stall watchdog: counts consecutive stalled RUN cycles, pulses trip_c on the
// LIMIT-th one and keeps a sticky error flag until clr_i or reset.
module seq_wdog #(
    parameter  int unsigned LIMIT = 16,
    localparam int unsigned CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    input  logic clr_i,
    output logic trip_c,
    output logic err_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Trip fires on the cycle that would make the run LIMIT consecutive stalls long.
    assign trip_c = stall_i && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (!stall_i || trip_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (clr_i) begin
            err_d = 1'b0;
        end else if (trip_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/seq_fsm_gen.sv
// Parametrised pattern sequencer with start/done handshake, wrap/one-shot,
// stall and abort. Optional stall watchdog enabled by STALL_WDOG_EN.
module seq_fsm_gen
    import seq_fsm_pkg::*;
#(
    parameter  int unsigned N_STATES   = N_STATES_DEF,
    parameter  int unsigned CNT_W      = CNT_W_DEF,
    parameter  int unsigned WDOG_LIMIT = WDOG_LIMIT_DEF,
    localparam int unsigned STATE_W    = $clog2(N_STATES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode_wrap,
    input  logic [N_STATES-1:0] pattern,
    input  logic                stall,
    input  logic                abort,
    output logic [STATE_W-1:0]  state_idx,
    output logic                out,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    wrap_cnt,
    output logic                wdog_err
);

    localparam logic [STATE_W-1:0] IDX_LAST = STATE_W'(N_STATES - 1);

    seq_state_e          state_q, state_d;
    logic [STATE_W-1:0]  idx_q, idx_d;
    logic [STATE_W-1:0]  idx_nx;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [N_STATES-1:0] pat_q, pat_d;
    logic                mode_q, mode_d;
    logic                start_acc_c;
    logic                stall_run_c;
    logic                wdog_trip_c;

    assign start_acc_c = (state_q == ST_IDLE) && start;
    assign stall_run_c = (state_q == ST_RUN) && stall && !abort;
    assign idx_nx      = idx_q + STATE_W'(1);

`ifdef STALL_WDOG_EN
    seq_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_run_c),
        .clr_i   (start_acc_c),
        .trip_c  (wdog_trip_c),
        .err_o   (wdog_err)
    );
`else
    logic unused_wdog;
    assign unused_wdog = ^{32'(WDOG_LIMIT), stall_run_c, start_acc_c};
    assign wdog_trip_c = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    // Next-state and registered-output logic; RUN priority is abort/watchdog > stall > advance.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wcnt_d  = wcnt_q;
        pat_d   = pat_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                idx_d  = '0;
                out_d  = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    pat_d   = pattern;
                    mode_d  = mode_wrap;
                    out_d   = pattern[0];
                    busy_d  = 1'b1;
                    wcnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (abort || wdog_trip_c) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (stall) begin
                    state_d = ST_RUN;
                end else if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    if (mode_q) begin
                        out_d  = pat_q[0];
                        wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + CNT_W'(1);
                    end else begin
                        state_d = ST_DONE;
                        out_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_nx;
                    out_d = pat_q[idx_nx];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
            pat_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wcnt_q  <= wcnt_d;
            pat_q   <= pat_d;
            mode_q  <= mode_d;
        end
    end

    assign state_idx = idx_q;
    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrap_cnt  = wcnt_q;

endmodule

// File: tb/tb_seq_fsm_gen.sv
// Directed bench for seq_fsm_gen: per-cycle vector table plus hand-written
// stall/watchdog sequences. Two instances share stimulus (CNT_W=8 and CNT_W=2).
module tb_seq_fsm_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode_wrap;
    logic [3:0] pattern;
    logic       stall;
    logic       abort;

    logic [1:0] idx_a, idx_b;
    logic       out_a, out_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic [7:0] wcnt_a;
    logic [1:0] wcnt_b;
    logic       werr_a, werr_b;

    int total = 0;
    int bad   = 0;

    seq_fsm_gen #(.N_STATES(4), .CNT_W(8), .WDOG_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_wrap(mode_wrap),
        .pattern(pattern), .stall(stall), .abort(abort),
        .state_idx(idx_a), .out(out_a), .busy(busy_a), .done(done_a),
        .wrap_cnt(wcnt_a), .wdog_err(werr_a)
    );

    seq_fsm_gen #(.N_STATES(4), .CNT_W(2), .WDOG_LIMIT(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .mode_wrap(mode_wrap),
        .pattern(pattern), .stall(stall), .abort(abort),
        .state_idx(idx_b), .out(out_b), .busy(busy_b), .done(done_b),
        .wrap_cnt(wcnt_b), .wdog_err(werr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       mode;
        logic [3:0] pat;
        logic       stall;
        logic       abort;
        logic [1:0] e_idx;
        logic       e_out;
        logic       e_busy;
        logic       e_done;
        logic [7:0] e_w8;
        logic [1:0] e_w2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic m, input logic [3:0] p,
                       input logic st, input logic ab, input int i, input logic o,
                       input logic b, input logic d, input int w8, input int w2);
        vec_t v;
        v.rst = r; v.start = s; v.mode = m; v.pat = p; v.stall = st; v.abort = ab;
        v.e_idx = 2'(i); v.e_out = o; v.e_busy = b; v.e_done = d;
        v.e_w8 = 8'(w8); v.e_w2 = 2'(w2);
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, row, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic m, input logic [3:0] p,
                         input logic st, input logic ab);
        rst = r; start = s; mode_wrap = m; pattern = p; stall = st; abort = ab;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] wp;
        int         k;
        rst = 1'b1; start = 1'b0; mode_wrap = 1'b0; pattern = '0; stall = 1'b0; abort = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        add(1,0,0,4'b0000,0,0, 0,0,0,0, 0,0);
        // one-shot pattern 0010; start/pattern change during RUN and start in DONE ignored
        add(0,1,0,4'b0010,0,0, 0,0,1,0, 0,0);
        add(0,1,1,4'b1111,0,0, 1,1,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 2,0,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 3,0,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 0,0,0,1, 0,0);
        add(0,1,1,4'b1111,0,0, 0,0,0,0, 0,0);
        add(0,0,0,4'b0000,0,0, 0,0,0,0, 0,0);
        // stall 3 cycles at idx 1, resume, then stall+abort
        add(0,1,0,4'b0010,0,0, 0,0,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 1,1,1,0, 0,0);
        add(0,0,0,4'b0000,1,0, 1,1,1,0, 0,0);
        add(0,0,0,4'b0000,1,0, 1,1,1,0, 0,0);
        add(0,0,0,4'b0000,1,0, 1,1,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 2,0,1,0, 0,0);
        add(0,0,0,4'b0000,1,1, 0,0,0,0, 0,0);
        add(0,0,0,4'b0000,0,0, 0,0,0,0, 0,0);
        // reset mid-run at idx 2
        add(0,1,1,4'b1011,0,0, 0,1,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 1,1,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 2,0,1,0, 0,0);
        add(1,0,0,4'b0000,0,0, 0,0,0,0, 0,0);
        add(0,0,0,4'b0000,0,0, 0,0,0,0, 0,0);
        // wrap mode, 20 advances = 5 wraps; CNT_W=2 instance saturates at 3
        wp = 4'b1011;
        add(0,1,1,wp,0,0, 0,wp[0],1,0, 0,0);
        for (int a = 1; a <= 20; a++) begin
            k = a % 4;
            add(0,0,0,4'b0000,0,0, k, wp[k], 1, 0, a / 4, (a / 4 > 3) ? 3 : a / 4);
        end
        // abort keeps wrap count; next start clears it
        add(0,0,0,4'b0000,0,1, 0,0,0,0, 5,3);
        add(0,1,0,4'b0001,0,0, 0,1,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 1,0,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 2,0,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 3,0,1,0, 0,0);
        add(0,0,0,4'b0000,0,0, 0,0,0,1, 0,0);
        add(0,0,0,4'b0000,0,0, 0,0,0,0, 0,0);

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].start, vecs[n].mode, vecs[n].pat,
                  vecs[n].stall, vecs[n].abort);
            chk("idx",      n, 32'(idx_a),  32'(vecs[n].e_idx));
            chk("out",      n, 32'(out_a),  32'(vecs[n].e_out));
            chk("busy",     n, 32'(busy_a), 32'(vecs[n].e_busy));
            chk("done",     n, 32'(done_a), 32'(vecs[n].e_done));
            chk("wrap_cnt", n, 32'(wcnt_a), 32'(vecs[n].e_w8));
            chk("wrap_sat", n, 32'(wcnt_b), 32'(vecs[n].e_w2));
            chk("idx_s",    n, 32'(idx_b),  32'(vecs[n].e_idx));
            chk("wdog_err", n, 32'(werr_a), 32'(0));
        end

        // long stall at idx 1
        drive(0,1,1,4'b0010,0,0);
        drive(0,0,0,4'b0000,0,0);
        chk("ls_idx", 0, 32'(idx_a), 32'(1));
`ifdef STALL_WDOG_EN
        for (int c = 1; c <= 3; c++) begin
            drive(0,0,0,4'b0000,1,0);
            chk("wd_busy", c, 32'(busy_a), 32'(1));
            chk("wd_idx",  c, 32'(idx_a),  32'(1));
            chk("wd_err",  c, 32'(werr_a), 32'(0));
        end
        drive(0,0,0,4'b0000,1,0);
        chk("wd_trip_busy", 4, 32'(busy_a), 32'(0));
        chk("wd_trip_idx",  4, 32'(idx_a),  32'(0));
        chk("wd_trip_err",  4, 32'(werr_a), 32'(1));
        chk("wd_trip_done", 4, 32'(done_a), 32'(0));
        drive(0,0,0,4'b0000,0,0);
        chk("wd_sticky", 5, 32'(werr_b), 32'(1));
        drive(0,1,0,4'b0010,0,0);
        chk("wd_clr_err",  6, 32'(werr_a), 32'(0));
        chk("wd_clr_busy", 6, 32'(busy_a), 32'(1));
        drive(0,0,0,4'b0000,0,1);
`else
        for (int c = 1; c <= 100; c++) begin
            drive(0,0,0,4'b0000,1,0);
            chk("ls_hold_idx", c, 32'(idx_a),  32'(1));
            chk("ls_hold_out", c, 32'(out_a),  32'(1));
            chk("ls_hold_bsy", c, 32'(busy_a), 32'(1));
            chk("ls_wdog",     c, 32'(werr_a), 32'(0));
        end
        drive(0,0,0,4'b0000,0,0);
        chk("ls_resume_idx", 101, 32'(idx_a), 32'(2));
        chk("ls_resume_out", 101, 32'(out_a), 32'(0));
        drive(0,0,0,4'b0000,0,1);
`endif
        chk("end_busy", 0, 32'(busy_a), 32'(0));
        chk("end_done", 0, 32'(done_a), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
